aes_block_loader: RTL and testbench
===================================

Name: aes_block_loader

Overview:
Byte-serial front end that feeds the 128-bit combinational AES encrypt/decrypt datapath. It assembles 16-byte key groups and 16-byte plaintext groups from an 8-bit valid/ready stream. It then presents a complete {key, plain_text} pair with a valid/ready handshake. The pair is held stable until the downstream consumer samples it, which isolates the wide datapath from the narrow host interface.

Parameters:
KEY_PERSIST, 1, 1 = key stays valid across blocks; 0 = key_loaded clears after each block handshake.
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  stream byte
in_is_key  input  1  sideband: 1 = byte belongs to a key group, 0 = plaintext group
in_valid  input  1  byte valid
in_ready  output  1  loader can accept a byte
blk_plain  output  128  assembled plaintext, [127:0]; first received byte in [127:120]
blk_key  output  [0:127]  committed key; first received byte in [0:7]
blk_valid  output  1  block pair valid
blk_ready  input  1  downstream accepts pair
key_loaded  output  1  a complete key is committed and usable
err_pulse  output  1  one-cycle pulse per discarded group
err_cnt  output  ERR_CNT_W  saturating count of discarded groups

Behaviour:
- Reset (async assert, sync deassert assumed upstream): state IDLE; byte count 0; shift register, blk_plain, blk_key, err_cnt all 0; in_ready=0 during reset, 1 first cycle after; blk_valid=0, key_loaded=0, err_pulse=0.
- Byte accepted iff in_valid && in_ready. Accepted bytes shift MSB-first into a 128-bit shift register; 4-bit count increments and wraps 15->0 on group completion.
- States: IDLE (count=0) -> LOAD_KEY or LOAD_TEXT on first accepted byte, chosen by in_is_key. LOAD_* -> IDLE on 16th byte (key group) or HOLD on 16th byte (text group with key_loaded=1). HOLD -> IDLE on blk_valid && blk_ready.
- Key completion: shift register (with 16th byte) commits to blk_key in the same edge; key_loaded=1 from the next cycle. Reloading a key replaces the previous one only at completion. The old key stays presented until then.
- Text completion with key_loaded=1: commit to blk_plain; blk_valid=1 in cycle N+1 when the 16th byte is accepted in cycle N. in_ready=0 throughout HOLD.
- Text completion with key_loaded=0: group discarded; blk_plain unchanged; err_pulse; return to IDLE.
- Mixed group: an accepted byte whose in_is_key differs from the current group type at count>0 discards the partial group and raises err_pulse. That byte starts a new group of its own type (count=1).
- HOLD: blk_plain, blk_key, blk_valid stable while blk_ready=0. After the handshake, blk_valid=0 and in_ready=1 in the next cycle; there is no same-cycle bypass. With KEY_PERSIST=0, key_loaded clears on the handshake; blk_key retains its value.
- err_cnt increments on each err_pulse and saturates at all-ones.
- Mid-operation reset: partial groups and held blocks are lost, and all outputs return to reset values immediately.
- in_valid with in_ready=0: the byte is not consumed; the source must hold it.

Decomposition:
- Package aes_io_pkg: BLOCK_BYTES=16, BYTE_W=8, loader state enum {IDLE, LOAD_KEY, LOAD_TEXT, HOLD}.
- Sub-module aes_byte_shreg: 128-bit MSB-first byte shift register with shift enable, clear, and 4-bit count with completion flag. It is shared by key and text loading.

Test Plan:
- Load key bytes 00..0f, then plaintext bytes 00,11,...,ff -> blk_key=000102030405060708090a0b0c0d0e0f, blk_plain=00112233445566778899aabbccddeeff, blk_valid one cycle after the 16th text byte; key_loaded=1 after the 16th key byte.
- Hold blk_ready=0 for 20 cycles with in_valid=1 -> in_ready=0, outputs stable; blk_ready=1 -> blk_valid=0 and in_ready=1 in the next cycle.
- Send plaintext 16 bytes after reset with no key -> err_pulse once, err_cnt=1, blk_valid stays 0.
- Send 5 key bytes, then a text byte -> err_pulse, err_cnt increments, and the new text group counts that byte as its first.
- KEY_PERSIST=0: two blocks after one key -> first emitted; second discarded with err_pulse. KEY_PERSIST=1 -> both emitted with the same blk_key.
- Assert rst_n=0 while in HOLD -> blk_valid, key_loaded, and err_cnt go to 0 immediately; post-reset, 16 text bytes are discarded.

Source files
------------

// File: rtl/aes_io_pkg.sv
// Shared constants and loader state encoding for the AES byte-serial front end.
package aes_io_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BYTE_W      = 8;
    localparam int BLOCK_W     = BLOCK_BYTES * BYTE_W;
    localparam int CNT_W       = 4;

    typedef logic [1:0] loader_state_t;

    localparam loader_state_t IDLE      = 2'd0;
    localparam loader_state_t LOAD_KEY  = 2'd1;
    localparam loader_state_t LOAD_TEXT = 2'd2;
    localparam loader_state_t HOLD      = 2'd3;

endpackage

// File: rtl/aes_byte_shreg.sv
// 128-bit MSB-first byte shift register with group byte count.
// clear+shift together restarts a group with the incoming byte as its first.
module aes_byte_shreg
    import aes_io_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift,
    input  logic               clear,
    input  logic [BYTE_W-1:0]  din,
    output logic [BLOCK_W-1:0] data,
    output logic [BLOCK_W-1:0] data_next,
    output logic [CNT_W-1:0]   count,
    output logic               last
);

    logic [BLOCK_W-1:0] base;

    // Next register image if this cycle's byte is shifted in.
    always_comb begin
        base      = clear ? '0 : data;
        data_next = {base[BLOCK_W-BYTE_W-1:0], din};
        // A restarted group can never complete on the same byte.
        last      = (count == CNT_W'(BLOCK_BYTES - 1)) && !clear;
    end

    // Shift bytes in; count wraps 15 -> 0 when a group completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            count <= '0;
        end else if (clear && shift) begin
            data  <= data_next;
            count <= CNT_W'(1);
        end else if (clear) begin
            data  <= '0;
            count <= '0;
        end else if (shift) begin
            data  <= data_next;
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/aes_block_loader.sv
// Byte-serial loader that assembles {key, plaintext} groups and presents a
// stable 128-bit pair to the combinational AES datapath via valid/ready.
module aes_block_loader
    import aes_io_pkg::*;
#(
    parameter int KEY_PERSIST = 1,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           in_data,
    input  logic                 in_is_key,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [127:0]         blk_plain,
    output logic [0:127]         blk_key,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic                 key_loaded,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    loader_state_t      state, state_nxt;
    logic               out_of_reset;
    logic               accept, in_group, mixed, complete;
    logic               key_done, text_done, discard, handshake;
    logic [BLOCK_W-1:0] sh_data, sh_next;
    logic [CNT_W-1:0]   sh_count;
    logic               sh_last;

    aes_byte_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift     (accept),
        .clear     (mixed),
        .din       (in_data),
        .data      (sh_data),
        .data_next (sh_next),
        .count     (sh_count),
        .last      (sh_last)
    );

    // Handshake decode and group-level events.
    always_comb begin
        blk_valid = (state == HOLD);
        in_ready  = out_of_reset && (state != HOLD);
        handshake = blk_valid && blk_ready;
        accept    = in_valid && in_ready;
        in_group  = (sh_count != '0);
        // A byte of the other type mid-group abandons the partial group.
        mixed     = accept && in_group && (in_is_key != (state == LOAD_KEY));
        complete  = accept && sh_last;
        key_done  = complete && in_is_key;
        text_done = complete && !in_is_key;
        discard   = mixed || (text_done && !key_loaded);
    end

    // Loader FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = in_is_key ? LOAD_KEY : LOAD_TEXT;
            end
            LOAD_KEY, LOAD_TEXT: begin
                if (mixed)          state_nxt = in_is_key ? LOAD_KEY : LOAD_TEXT;
                else if (key_done)  state_nxt = IDLE;
                else if (text_done) state_nxt = key_loaded ? HOLD : IDLE;
            end
            HOLD: begin
                if (handshake) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, committed key/plaintext, key flag and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_of_reset <= 1'b0;
            blk_plain    <= '0;
            blk_key      <= '0;
            key_loaded   <= 1'b0;
            err_pulse    <= 1'b0;
            err_cnt      <= '0;
        end else begin
            state        <= state_nxt;
            out_of_reset <= 1'b1;
            err_pulse    <= discard;
            if (key_done) begin
                blk_key    <= sh_next;
                key_loaded <= 1'b1;
            end else if (handshake && (KEY_PERSIST == 0)) begin
                key_loaded <= 1'b0;
            end
            if (text_done && key_loaded) blk_plain <= sh_next;
            if (discard && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Scoreboard bench for aes_block_loader: a group-level model predicts emitted
// blocks and discarded groups; a monitor pops and compares on each handshake.
module tb_aes_block_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_is_key, in_valid, in_ready;
    logic [127:0] blk_plain;
    logic [0:127] blk_key;
    logic         blk_valid, blk_ready, key_loaded, err_pulse;
    logic [7:0]   err_cnt;

    logic [7:0]   p_in_data;
    logic         p_in_is_key, p_in_valid, p_in_ready;
    logic [127:0] p_blk_plain;
    logic [0:127] p_blk_key;
    logic         p_blk_valid, p_blk_ready, p_key_loaded, p_err_pulse;
    logic [7:0]   p_err_cnt;

    aes_block_loader #(.KEY_PERSIST(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_is_key(in_is_key),
        .in_valid(in_valid), .in_ready(in_ready), .blk_plain(blk_plain), .blk_key(blk_key),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .key_loaded(key_loaded),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    aes_block_loader #(.KEY_PERSIST(0), .ERR_CNT_W(8)) dut_np (
        .clk(clk), .rst_n(rst_n), .in_data(p_in_data), .in_is_key(p_in_is_key),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .blk_plain(p_blk_plain),
        .blk_key(p_blk_key), .blk_valid(p_blk_valid), .blk_ready(p_blk_ready),
        .key_loaded(p_key_loaded), .err_pulse(p_err_pulse), .err_cnt(p_err_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model (KEY_PERSIST=1 instance) ----------------
    logic [7:0]   grp[$];
    bit           grp_key;
    bit           m_key_loaded;
    logic [127:0] m_key;
    logic [255:0] exp_q[$];
    int           exp_err, obs_err;

    function automatic logic [127:0] pack_grp();
        logic [127:0] v = '0;
        foreach (grp[i]) v[127-8*i -: 8] = grp[i];
        return v;
    endfunction

    function automatic void model_reset();
        grp.delete();
        m_key_loaded = 0;
        m_key        = '0;
        exp_q.delete();
        exp_err = 0;
        obs_err = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b, input bit k);
        if (grp.size() > 0 && k != grp_key) begin
            exp_err++;
            grp.delete();
        end
        if (grp.size() == 0) grp_key = k;
        grp.push_back(b);
        if (grp.size() == 16) begin
            if (k) begin
                m_key        = pack_grp();
                m_key_loaded = 1;
            end else if (m_key_loaded) begin
                exp_q.push_back({m_key, pack_grp()});
            end else begin
                exp_err++;
            end
            grp.delete();
        end
    endfunction

    // ---------------- drivers ----------------
    int rdy_mode = 0;  // 0: low, 1: high, 2: random
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      blk_ready = 1'b0;
        else if (rdy_mode == 1) blk_ready = 1'b1;
        else                    blk_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_byte(input logic [7:0] b, input bit k);
        bit acc = 0;
        int n   = 0;
        in_data   = b;
        in_is_key = k;
        in_valid  = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) model_accept(b, k);
        else begin
            checks++;
            errors++;
            $display("FAIL send_byte: byte %h not accepted, in_ready %b expected 1", b, in_ready);
        end
    endtask

    task automatic send_p(input logic [7:0] b, input bit k);
        bit acc = 0;
        int n   = 0;
        p_in_data   = b;
        p_in_is_key = k;
        p_in_valid  = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = p_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        p_in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_p: byte %h not accepted, in_ready %b expected 1", b, p_in_ready);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit           prev_hold, prev_hs;
    logic [127:0] prev_plain, prev_key;
    int           p_hs = 0;

    always @(negedge clk) begin
        logic [255:0] e;
        if (!rst_n) begin
            prev_hold = 0;
            prev_hs   = 0;
        end else begin
            if (err_pulse) obs_err++;
            if (p_blk_valid && p_blk_ready) p_hs++;
            if (prev_hs) begin
                check("post_hs_valid", 128'(blk_valid), 128'(0));
                check("post_hs_in_ready", 128'(in_ready), 128'(1));
            end
            if (prev_hold) begin
                check("hold_valid", 128'(blk_valid), 128'(1));
                check("hold_plain", blk_plain, prev_plain);
                check("hold_key", blk_key, prev_key);
            end
            if (blk_valid) check("hold_in_ready", 128'(in_ready), 128'(0));
            if (blk_valid && blk_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: plain %h emitted, expected none", blk_plain);
                end else begin
                    e = exp_q.pop_front();
                    check("blk_key", blk_key, e[255:128]);
                    check("blk_plain", blk_plain, e[127:0]);
                end
            end
            prev_hold  = blk_valid && !blk_ready;
            prev_hs    = blk_valid && blk_ready;
            prev_plain = blk_plain;
            prev_key   = blk_key;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int len;
        bit k;
        rst_n = 1'b0;
        in_data = '0; in_is_key = 0; in_valid = 0; blk_ready = 0;
        p_in_data = '0; p_in_is_key = 0; p_in_valid = 0; p_blk_ready = 1'b1;
        model_reset();
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_blk_valid", 128'(blk_valid), 128'(0));
        check("rst_key_loaded", 128'(key_loaded), 128'(0));
        check("rst_err_cnt", 128'(err_cnt), 128'(0));
        check("rst_err_pulse", 128'(err_pulse), 128'(0));
        check("rst_blk_key", blk_key, 128'(0));
        check("rst_blk_plain", blk_plain, 128'(0));
        repeat (3) @(posedge clk);
        #1 check("rst_in_ready_held", 128'(in_ready), 128'(0));
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Directed key then plaintext.
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 14) check("key_loaded_early", 128'(key_loaded), 128'(0));
        end
        check("key_loaded", 128'(key_loaded), 128'(1));
        check("dir_key", blk_key, 128'h000102030405060708090a0b0c0d0e0f);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i * 17), 1'b0);
            if (i == 14) check("valid_early", 128'(blk_valid), 128'(0));
        end
        check("dir_valid", 128'(blk_valid), 128'(1));
        check("dir_plain", blk_plain, 128'h00112233445566778899aabbccddeeff);

        // Back-pressure for 20 cycles with a pending byte.
        in_data = 8'haa; in_is_key = 1'b0; in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("hold20_in_ready", 128'(in_ready), 128'(0));
        end
        in_valid = 1'b0;
        rdy_mode = 1;
        repeat (4) @(posedge clk);
        #1 check("hold20_drained", 128'(exp_q.size()), 128'(0));

        // Partial key interrupted by a text byte.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'h5a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("mixed_err_cnt", 128'(err_cnt), 128'(1));
        check("mixed_obs_err", 128'(obs_err), 128'(exp_err));
        for (int i = 0; i < 15; i++) send_byte(8'($urandom), 1'b0);
        repeat (4) @(posedge clk);
        #1 check("mixed_drained", 128'(exp_q.size()), 128'(0));

        // Randomised groups with random back-pressure.
        rdy_mode = 2;
        for (int g = 0; g < 40; g++) begin
            k   = ($urandom_range(0, 3) == 0);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : 16;
            for (int i = 0; i < len; i++) send_byte(8'($urandom), k);
        end
        rdy_mode = 1;
        repeat (5) @(posedge clk);
        #1;
        check("rand_drained", 128'(exp_q.size()), 128'(0));
        check("rand_err_events", 128'(obs_err), 128'(exp_err));

        // Alternating types: every byte after the first discards a group.
        for (int i = 0; i < 300; i++) send_byte(8'(i), i[0]);
        repeat (3) @(posedge clk);
        #1;
        check("sat_err_events", 128'(obs_err), 128'(exp_err));
        check("sat_err_cnt", 128'(err_cnt), 128'((exp_err > 255) ? 255 : exp_err));

        // Reset while a block is held.
        rdy_mode = 0;
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        check("pre_rst_hold", 128'(blk_valid), 128'(1));
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 128'(blk_valid), 128'(0));
        check("midrst_key_loaded", 128'(key_loaded), 128'(0));
        check("midrst_err_cnt", 128'(err_cnt), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("nokey_err_cnt", 128'(err_cnt), 128'(1));
        check("nokey_obs_err", 128'(obs_err), 128'(1));
        check("nokey_valid", 128'(blk_valid), 128'(0));

        // KEY_PERSIST=0 instance: one key serves exactly one block.
        for (int i = 0; i < 16; i++) send_p(8'(8'h10 + i), 1'b1);
        for (int i = 0; i < 16; i++) send_p(8'(i), 1'b0);
        check("np_valid", 128'(p_blk_valid), 128'(1));
        check("np_plain", p_blk_plain, 128'h000102030405060708090a0b0c0d0e0f);
        check("np_key", p_blk_key, 128'h101112131415161718191a1b1c1d1e1f);
        @(posedge clk);
        #1;
        check("np_post_valid", 128'(p_blk_valid), 128'(0));
        check("np_key_cleared", 128'(p_key_loaded), 128'(0));
        check("np_key_kept", p_blk_key, 128'h101112131415161718191a1b1c1d1e1f);
        for (int i = 0; i < 16; i++) send_p(8'(8'hf0 + i), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("np_err_cnt", 128'(p_err_cnt), 128'(1));
        check("np_valid_2nd", 128'(p_blk_valid), 128'(0));
        check("np_blocks", 128'(p_hs), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
